// File: rtl/thermal_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : thermal_tx_scheduler
// Description : Slot-timed scheduler for a thermal covert-channel transmitter.
//               It sends a preamble, then the data byte MSB first, then an
//               optional parity slot, then a heater-off guard slot.
//               Define THERMAL_TX_PARITY_EN to add the even-parity slot.
// Revision    : 1.0 - initial release
// ============================================================================
module thermal_tx_scheduler #(
    parameter logic [31:0] SLOT_CYCLES  = 32'd720_000_000,
    parameter logic [31:0] GUARD_CYCLES = 32'd120_000_000,
    parameter int unsigned PRE_LEN      = 4,
    parameter logic [7:0]  PRE_PATTERN  = 8'b0000_1010
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  tx_data,
    input  logic        tx_valid,
    output logic        tx_ready,
    input  logic        abort,
    output logic        heater_en,
    output logic        slot_strobe,
    output logic        busy,
    output logic [3:0]  bit_index,
    output logic [15:0] frames_sent
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PREAMBLE = 3'd1,
        ST_DATA     = 3'd2,
`ifdef THERMAL_TX_PARITY_EN
        ST_PARITY   = 3'd3,
`endif
        ST_GUARD    = 3'd4
    } state_t;

    localparam logic [31:0] c_slot_last  = SLOT_CYCLES - 32'd1;
    localparam logic [31:0] c_guard_last = GUARD_CYCLES - 32'd1;
    localparam logic [2:0]  c_pre_top    = 3'(PRE_LEN - 1);

    state_t      r_state;
    state_t      w_state_nx;
    logic [31:0] r_slot_cnt;
    logic [31:0] w_slot_cnt_nx;
    logic [3:0]  r_bit_index;
    logic [3:0]  w_bit_index_nx;
    logic [7:0]  r_byte;
    logic [7:0]  w_byte_nx;
    logic        r_heater;
    logic        w_heater_nx;
    logic [15:0] r_frames;
    logic [15:0] w_frames_nx;

    logic        w_busy;
    logic        w_slot_last;
    logic        w_accept;
    logic [2:0]  w_idx_dec;

    assign w_busy      = (r_state != ST_IDLE);
    assign w_slot_last = (r_state == ST_GUARD) ? (r_slot_cnt == c_guard_last)
                                               : (r_slot_cnt == c_slot_last);
    assign tx_ready    = (r_state == ST_IDLE) && !abort && !reset;
    assign w_accept    = tx_valid && tx_ready;
    assign w_idx_dec   = r_bit_index[2:0] - 3'd1;

    assign heater_en   = r_heater;
    assign slot_strobe = w_busy && w_slot_last;
    assign busy        = w_busy;
    assign bit_index   = r_bit_index;
    assign frames_sent = r_frames;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_slot_cnt  <= 32'd0;
            r_bit_index <= 4'd0;
            r_byte      <= 8'd0;
            r_heater    <= 1'b0;
            r_frames    <= 16'd0;
        end else begin
            r_state     <= w_state_nx;
            r_slot_cnt  <= w_slot_cnt_nx;
            r_bit_index <= w_bit_index_nx;
            r_byte      <= w_byte_nx;
            r_heater    <= w_heater_nx;
            r_frames    <= w_frames_nx;
        end
    end

    // The heater register is loaded with the bit of the slot being entered,
    // so heater_en changes in the same cycle as the state.
    always_comb begin
        w_state_nx     = r_state;
        w_slot_cnt_nx  = r_slot_cnt;
        w_bit_index_nx = r_bit_index;
        w_byte_nx      = r_byte;
        w_heater_nx    = r_heater;
        w_frames_nx    = r_frames;

        if (w_busy) begin
            w_slot_cnt_nx = w_slot_last ? 32'd0 : r_slot_cnt + 32'd1;
        end

        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_byte_nx      = tx_data;
                    w_state_nx     = ST_PREAMBLE;
                    w_slot_cnt_nx  = 32'd0;
                    w_bit_index_nx = {1'b0, c_pre_top};
                    w_heater_nx    = PRE_PATTERN[c_pre_top];
                end
            end
            ST_PREAMBLE: begin
                if (w_slot_last) begin
                    if (r_bit_index == 4'd0) begin
                        w_state_nx     = ST_DATA;
                        w_bit_index_nx = 4'd7;
                        w_heater_nx    = r_byte[7];
                    end else begin
                        w_bit_index_nx = {1'b0, w_idx_dec};
                        w_heater_nx    = PRE_PATTERN[w_idx_dec];
                    end
                end
            end
            ST_DATA: begin
                if (w_slot_last) begin
                    if (r_bit_index == 4'd0) begin
`ifdef THERMAL_TX_PARITY_EN
                        w_state_nx     = ST_PARITY;
                        w_bit_index_nx = 4'd0;
                        w_heater_nx    = ^r_byte;
`else
                        w_state_nx     = ST_GUARD;
                        w_bit_index_nx = 4'd0;
                        w_heater_nx    = 1'b0;
`endif
                    end else begin
                        w_bit_index_nx = {1'b0, w_idx_dec};
                        w_heater_nx    = r_byte[w_idx_dec];
                    end
                end
            end
`ifdef THERMAL_TX_PARITY_EN
            ST_PARITY: begin
                if (w_slot_last) begin
                    w_state_nx     = ST_GUARD;
                    w_bit_index_nx = 4'd0;
                    w_heater_nx    = 1'b0;
                end
            end
`endif
            ST_GUARD: begin
                if (w_slot_last) begin
                    w_state_nx  = ST_IDLE;
                    w_frames_nx = r_frames + 16'd1;
                end
            end
            default: begin
                w_state_nx     = ST_IDLE;
                w_slot_cnt_nx  = 32'd0;
                w_bit_index_nx = 4'd0;
                w_heater_nx    = 1'b0;
            end
        endcase

        // Abort drops the frame outright; the frame counter is not advanced.
        if (abort && w_busy) begin
            w_state_nx     = ST_IDLE;
            w_slot_cnt_nx  = 32'd0;
            w_bit_index_nx = 4'd0;
            w_heater_nx    = 1'b0;
            w_frames_nx    = r_frames;
        end
    end

endmodule
`default_nettype wire
